fir_sample_pacer: RTL
=====================

// Module: fir_sample_pacer
// PURPOSE
//  Upstream feeder for the 32-tap serial FIR stage. Accepts 16-bit samples on a valid/ready
//  handshake from the ADC/capture side and buffers them in a small FIFO. Releases one sample
//  per PERIOD clocks as a registered xIn word plus a one-cycle sample strobe. This guarantees
//  the FIR's 32-cycle MAC pass always completes before the next sample shifts in.
// PARAMETERS
//  DATA_W      16   sample width (must equal FIR xIn width)
//  DEPTH       8    FIFO entries, power of two, >=2
//  PERIOD      34   clocks between sample slots; legal range 33..65535 (>= TAPS+1)
//  OFFSET_BIN  0    1: input is offset-binary, invert MSB to two's complement on pop
// PORTS
//  clk        in   1       system clock, all logic on rising edge
//  reset      in   1       asynchronous, active-low reset
//  en         in   1       1: pacing counter runs; 0: counter held at 0, no strobes
//  in_data    in   DATA_W  upstream sample
//  in_valid   in   1       in_data valid
//  in_ready   out  1       FIFO can accept (registered, = ~full)
//  xIn        out  DATA_W  sample to FIR, held between strobes
//  sample     out  1       one-cycle strobe; xIn is valid in the same cycle
//  level      out  $clog2(DEPTH)+1  current FIFO occupancy
//  underrun   out  1       sticky: a slot arrived with FIFO empty
//  clr_flags  in   1       synchronous clear of underrun
// BEHAVIOUR
//  Reset (reset=0, async): xIn=0, sample=0, in_ready=1, level=0, underrun=0,
//   cnt=0, FIFO pointers=0, FSM=IDLE. Deassertion is synchronised externally.
//  Push: on in_valid & in_ready, store in_data at wr_ptr. in_ready is computed from the
//   registered level, so a full FIFO refuses a push even if a pop occurs in the same cycle.
//  Pacing counter cnt: while en=1, counts 0..PERIOD-1 and wraps; slot_tick = (cnt==PERIOD-1).
//   en=0 resets cnt to 0 on the next edge.
//  FSM (registered):
//   IDLE: en=0. Go to RUN when en=1.
//   RUN: on slot_tick, go to ISSUE if level!=0; otherwise set underrun=1 and stay in RUN.
//    en=0 returns to IDLE.
//   ISSUE: one cycle. sample=1, xIn = head (MSB inverted if OFFSET_BIN), then pop.
//    Return to RUN, or to IDLE if en=0. An en drop during ISSUE still completes the pop.
//  The strobe is therefore 1 clk after slot_tick. Strobe spacing is exactly PERIOD clocks
//   while data is available. After an empty slot, the next strobe waits for the following slot.
//  Simultaneous push and pop: level unchanged, both pointers advance. Pointers wrap modulo DEPTH.
//  xIn holds its last value between strobes and is never cleared except by reset.
//  underrun: set wins over clr_flags in the same cycle.
//  First-sample latency: push into an empty FIFO at cycle t -> strobe at the first
//   slot_tick after t, plus 1.
//  Reset mid-operation discards FIFO contents; no partial strobe is emitted.
// STRUCTURE
//  Shared header fir_defs.vh: FIR_DATA_W=16, FIR_TAPS=32, FIR_MIN_PERIOD=FIR_TAPS+1,
//   and FSM state encodings (IDLE=2'd0, RUN=2'd1, ISSUE=2'd2).
//  Sub-module fir_sync_fifo (DATA_W, DEPTH): registered level, full/empty, async active-low reset.
//   Read data is combinational from the head entry.
//  Top level contains the pacing counter, FSM, output registers and flag logic.
//  Elaboration check: PERIOD < FIR_MIN_PERIOD -> $error.
// TESTING
//  1 Reset: hold reset=0 with in_valid=1 -> in_ready=1, sample=0, xIn=0, level=0 throughout.
//  2 Steady stream: en=1, push 16'h0001,16'h7FFF,16'h8000 -> strobes at cycles PERIOD,
//    2*PERIOD, 3*PERIOD after en; xIn in that order; sample high exactly 1 clk each.
//  3 Full: en=0, push 9 words with DEPTH=8 -> in_ready=0 after the 8th; 9th not accepted;
//    level=8. Set en=1 -> in_ready=1 one clk after the first pop.
//  4 Underrun: en=1, FIFO empty for 2 slots -> no strobe, underrun=1. Push 16'h1234 -> strobe
//    at the next slot with xIn=16'h1234. clr_flags -> underrun=0.
//  5 OFFSET_BIN=1: push 16'h0000,16'hFFFF -> xIn=16'h8000, 16'h7FFF.
//  6 Async reset asserted mid-ISSUE with level=3 -> outputs to reset values immediately;
//    level=0 after release; no strobe until new data and a full PERIOD elapse.

Source files
------------

// File: rtl/fir_sample_pacer_pkg.sv
// Shared constants and FSM encoding for the FIR sample pacer.
package fir_sample_pacer_pkg;
    localparam int FIR_DATA_W     = 16;
    localparam int FIR_TAPS       = 32;
    localparam int FIR_MIN_PERIOD = FIR_TAPS + 1;
    localparam int CNT_W          = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ISSUE = 2'd2
    } state_t;
endpackage

// File: rtl/fir_sample_pacer_if.sv
// Upstream sample handshake plus the paced xIn/sample output toward the FIR.
interface fir_sample_pacer_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] xIn;
    logic              sample;

    modport master (output in_data, output in_valid, input in_ready, input xIn, input sample);
    modport slave  (input in_data, input in_valid, output in_ready, output xIn, output sample);
endinterface

// File: rtl/fir_sample_pacer_fifo.sv
// Purpose: small synchronous FIFO with registered occupancy and combinational head read.
// Latency: a pushed word is visible at head the cycle after the push edge.
// Backpressure: pushes while full are dropped; full derives from the registered level only.
module fir_sync_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_dat,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [AW:0]       level,
    output logic              full,
    output logic              empty
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/fir_sample_pacer.sv
// Purpose: buffers upstream samples and releases one per PERIOD clocks to a serial FIR.
// Latency: strobe lands one clock after the slot tick; backpressure via in_ready = ~full.
module fir_sample_pacer
    import fir_sample_pacer_pkg::*;
#(
    parameter int DATA_W     = FIR_DATA_W,
    parameter int DEPTH      = 8,
    parameter int PERIOD     = 34,
    parameter bit OFFSET_BIN = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     clr_flags,
    fir_sample_pacer_if.slave        bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     underrun
);
    localparam logic [DATA_W-1:0] MSB_MASK = OFFSET_BIN ? {1'b1, {(DATA_W-1){1'b0}}} : '0;

    if (PERIOD < FIR_MIN_PERIOD) begin : g_period_chk
        $error("fir_sample_pacer: PERIOD shorter than one full FIR MAC pass");
    end

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              slot_tick;
    logic [DATA_W-1:0] head;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] xin_q;
    logic              sample_q;

    assign slot_tick    = en && (cnt == CNT_W'(PERIOD - 1));
    assign bus.in_ready = ~full;
    assign bus.xIn      = xin_q;
    assign bus.sample   = sample_q;

    fir_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (bus.in_valid),
        .push_dat (bus.in_data),
        .pop      (state == ISSUE),
        .head     (head),
        .level    (level),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!en || slot_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Sample and xIn are loaded on entry to ISSUE so the strobe is registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            xin_q    <= '0;
            sample_q <= 1'b0;
            underrun <= 1'b0;
        end else begin
            sample_q <= 1'b0;
            case (state)
                IDLE: if (en) state <= RUN;
                RUN: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (slot_tick && !empty) begin
                        state    <= ISSUE;
                        sample_q <= 1'b1;
                        xin_q    <= head ^ MSB_MASK;
                    end
                end
                ISSUE:   state <= en ? RUN : IDLE;
                default: state <= IDLE;
            endcase

            if (state == RUN && slot_tick && empty) begin
                underrun <= 1'b1;
            end else if (clr_flags) begin
                underrun <= 1'b0;
            end
        end
    end
endmodule
